// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained by a round-robin
// arbiter onto NUM_PORTS broadcast ports, with branch squash/clear of masks.
module cdb_arbiter #(
  parameter int NUM_SRC      = 5,
  parameter int NUM_PORTS    = 2,
  parameter int DEPTH        = 2,
  parameter int PREG_BITS    = 6,
  parameter int ROB_BITS     = 4,
  parameter int BR_MASK_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*32-1:0]             src_data,
  input  logic [NUM_SRC*PREG_BITS-1:0]      src_pd,
  input  logic [NUM_SRC*5-1:0]              src_rd,
  input  logic [NUM_SRC*ROB_BITS-1:0]       src_rob_idx,
  input  logic [NUM_SRC*BR_MASK_BITS-1:0]   src_br_mask,
  input  logic                              br_valid,
  input  logic                              br_mispredict,
  input  logic [BR_MASK_BITS-1:0]           br_tag,
  output logic [NUM_PORTS-1:0]              cdb_valid,
  output logic [NUM_PORTS*32-1:0]           cdb_data,
  output logic [NUM_PORTS*PREG_BITS-1:0]    cdb_pd,
  output logic [NUM_PORTS*5-1:0]            cdb_rd,
  output logic [NUM_PORTS*ROB_BITS-1:0]     cdb_rob_idx,
  output logic [31:0]                       conflict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int EW = $clog2(NUM_SRC + 1);
  localparam logic [EW-1:0] NP = EW'(NUM_PORTS);

  logic [31:0]             data_q [NUM_SRC][DEPTH];
  logic [PREG_BITS-1:0]    pd_q   [NUM_SRC][DEPTH];
  logic [4:0]              rd_q   [NUM_SRC][DEPTH];
  logic [ROB_BITS-1:0]     rob_q  [NUM_SRC][DEPTH];
  logic [BR_MASK_BITS-1:0] mask_q [NUM_SRC][DEPTH];
  logic                    vld_q  [NUM_SRC][DEPTH];
  logic [AW-1:0]           head_q [NUM_SRC];
  logic [AW-1:0]           tail_q [NUM_SRC];
  logic [CW-1:0]           cnt_q  [NUM_SRC];
  logic [RW-1:0]           rr_ptr;

  logic                    mispred, correct;
  logic [NUM_SRC-1:0]      elig, drop, grant, push, pop;
  logic [RW-1:0]           port_src [NUM_PORTS];
  logic [NUM_PORTS-1:0]    port_vld;
  logic [RW-1:0]           last_src;
  logic [EW-1:0]           n_elig;
  int                      arb_n, arb_idx;

  assign mispred = br_valid & br_mispredict;
  assign correct = br_valid & ~br_mispredict;

  // A head squashed by this cycle's mispredict is dropped, not broadcast.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i]      = (cnt_q[i] != '0) && vld_q[i][head_q[i]] &&
                     !(mispred && |(mask_q[i][head_q[i]] & br_tag));
      drop[i]      = (cnt_q[i] != '0) && !elig[i];
      src_ready[i] = (cnt_q[i] != CW'(DEPTH));
      push[i]      = src_valid[i] & src_ready[i];
    end
  end

  always_comb begin
    grant    = '0;
    port_vld = '0;
    last_src = '0;
    n_elig   = '0;
    arb_n    = 0;
    arb_idx  = 0;
    for (int p = 0; p < NUM_PORTS; p++) port_src[p] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_SRC) arb_idx = arb_idx - NUM_SRC;
      if (elig[arb_idx]) begin
        n_elig = n_elig + 1'b1;
        if (arb_n < NUM_PORTS) begin
          grant[arb_idx]  = 1'b1;
          port_src[arb_n] = RW'(arb_idx);
          port_vld[arb_n] = 1'b1;
          last_src        = RW'(arb_idx);
          arb_n           = arb_n + 1;
        end
      end
    end
  end

  assign pop = grant | drop;

  always_comb begin
    cdb_valid   = port_vld;
    cdb_data    = '0;
    cdb_pd      = '0;
    cdb_rd      = '0;
    cdb_rob_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_vld[p]) begin
        cdb_data[p*32 +: 32]                = data_q[port_src[p]][head_q[port_src[p]]];
        cdb_pd[p*PREG_BITS +: PREG_BITS]    = pd_q[port_src[p]][head_q[port_src[p]]];
        cdb_rd[p*5 +: 5]                    = rd_q[port_src[p]][head_q[port_src[p]]];
        cdb_rob_idx[p*ROB_BITS +: ROB_BITS] = rob_q[port_src[p]][head_q[port_src[p]]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          data_q[i][j] <= '0;
          pd_q[i][j]   <= '0;
          rd_q[i][j]   <= '0;
          rob_q[i][j]  <= '0;
          mask_q[i][j] <= '0;
          vld_q[i][j]  <= 1'b0;
        end
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (mispred && |(mask_q[i][j] & br_tag)) vld_q[i][j] <= 1'b0;
          if (correct) mask_q[i][j] <= mask_q[i][j] & ~br_tag;
        end
        // The tail slot is free whenever push is allowed, so this write wins safely.
        if (push[i]) begin
          data_q[i][tail_q[i]] <= src_data[i*32 +: 32];
          pd_q[i][tail_q[i]]   <= src_pd[i*PREG_BITS +: PREG_BITS];
          rd_q[i][tail_q[i]]   <= src_rd[i*5 +: 5];
          rob_q[i][tail_q[i]]  <= src_rob_idx[i*ROB_BITS +: ROB_BITS];
          mask_q[i][tail_q[i]] <= correct ? (src_br_mask[i*BR_MASK_BITS +: BR_MASK_BITS] & ~br_tag)
                                          : src_br_mask[i*BR_MASK_BITS +: BR_MASK_BITS];
          vld_q[i][tail_q[i]]  <= !(mispred && |(src_br_mask[i*BR_MASK_BITS +: BR_MASK_BITS] & br_tag));
          tail_q[i]            <= tail_q[i] + 1'b1;
        end
        if (pop[i]) head_q[i] <= head_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (|grant) rr_ptr <= (last_src == RW'(NUM_SRC - 1)) ? '0 : last_src + 1'b1;
      if (n_elig > NP && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule
